// File: rtl/multicycle_ctrl_unit.sv
// multicycle_ctrl_unit: multi-cycle control FSM for the MIPS-subset CPU.
// Sequences IF/ID/EXE/MEM/WB and drives every datapath enable and select,
// including the extender's ExtSel. All outputs are decoded combinationally
// from (state, latched opcode, zero).
// Optional build macro: ILLEGAL_OP_TRAP_EN (trap on unknown opcodes and
// adds the illegal_op output; otherwise unknown opcodes retire as a nop).
module multicycle_ctrl_unit #(
    parameter int OPW = 6,
    parameter int STW = 3
) (
    input  logic           CLK,
    input  logic           Reset,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           PCWre,
    output logic           IRWre,
    output logic           ExtSel,
    output logic           ALUSrcB,
    output logic [2:0]     ALUOp,
    output logic           RegWre,
    output logic           RegDst,
    output logic           DBDataSrc,
    output logic           mRD,
    output logic           mWR,
    output logic [1:0]     PCSrc,
    output logic           halted,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic           illegal_op,
`endif
    output logic [STW-1:0] state
);

    typedef enum logic [STW-1:0] {
        S_IF    = 3'b000,
        S_ID    = 3'b001,
        S_EXE_A = 3'b110,
        S_EXE_B = 3'b101,
        S_EXE_L = 3'b010,
        S_MEM   = 3'b011,
        S_WB_A  = 3'b111,
        S_WB_L  = 3'b100
    } state_e;

    localparam logic [OPW-1:0] OP_ADD   = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(6'b000001);
    localparam logic [OPW-1:0] OP_ADDIU = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_SLTI  = OPW'(6'b011100);
    localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b010000);
    localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b010010);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b100110);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100111);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b110000);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b110001);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b111000);
    localparam logic [OPW-1:0] OP_HALT  = OPW'(6'b111111);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    state_e         state_q, state_d;
    logic [OPW-1:0] op_q;

    // Decoded view of the latched opcode
    logic       is_alu, is_rtype, is_lw, is_sw, is_beq, is_bne;
    logic       is_j, is_halt, ext_sel;
    logic [2:0] alu_op;
    logic       br_taken;

    // State register; reset can land at any point of an instruction
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode latch: captured on the IF->ID edge, held until the next IF
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            op_q <= '0;
        end else if (state_q == S_IF) begin
            op_q <= opcode;
        end
    end

    // Opcode decode
    always_comb begin
        is_alu   = 1'b0;
        is_rtype = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_j     = 1'b0;
        is_halt  = 1'b0;
        ext_sel  = 1'b0;
        alu_op   = ALU_ADD;
        case (op_q)
            OP_ADD: begin
                is_alu   = 1'b1;
                is_rtype = 1'b1;
                alu_op   = ALU_ADD;
            end
            OP_SUB: begin
                is_alu   = 1'b1;
                is_rtype = 1'b1;
                alu_op   = ALU_SUB;
            end
            OP_ADDIU: begin
                is_alu  = 1'b1;
                ext_sel = 1'b1;
                alu_op  = ALU_ADD;
            end
            OP_SLTI: begin
                is_alu  = 1'b1;
                ext_sel = 1'b1;
                alu_op  = ALU_SLT;
            end
            OP_ANDI: begin
                is_alu = 1'b1;
                alu_op = ALU_AND;
            end
            OP_ORI: begin
                is_alu = 1'b1;
                alu_op = ALU_OR;
            end
            OP_SW: begin
                is_sw   = 1'b1;
                ext_sel = 1'b1;
            end
            OP_LW: begin
                is_lw   = 1'b1;
                ext_sel = 1'b1;
            end
            OP_BEQ: begin
                is_beq  = 1'b1;
                ext_sel = 1'b1;
                alu_op  = ALU_SUB;
            end
            OP_BNE: begin
                is_bne  = 1'b1;
                ext_sel = 1'b1;
                alu_op  = ALU_SUB;
            end
            OP_J:    is_j    = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
        br_taken = (is_beq & zero) | (is_bne & ~zero);
    end

    // Next-state and datapath control decode
    always_comb begin
        state_d   = state_q;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        ExtSel    = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = ALU_ADD;
        RegWre    = 1'b0;
        RegDst    = 1'b0;
        DBDataSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        PCSrc     = PC_SEQ;
        halted    = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
        illegal_op = 1'b0;
`endif
        case (state_q)
            S_IF: begin
                IRWre   = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                ExtSel = ext_sel;
                if (is_alu) begin
                    state_d = S_EXE_A;
                end else if (is_lw || is_sw) begin
                    state_d = S_EXE_L;
                end else if (is_beq || is_bne) begin
                    state_d = S_EXE_B;
                end else if (is_j) begin
                    PCWre   = 1'b1;
                    PCSrc   = PC_JMP;
                    state_d = S_IF;
                end else if (is_halt) begin
                    halted  = 1'b1;
                    state_d = S_ID;
                end else begin
`ifdef ILLEGAL_OP_TRAP_EN
                    halted     = 1'b1;
                    illegal_op = 1'b1;
                    state_d    = S_ID;
`else
                    PCWre   = 1'b1;
                    state_d = S_IF;
`endif
                end
            end
            S_EXE_A: begin
                ExtSel  = ext_sel;
                ALUSrcB = ~is_rtype;
                ALUOp   = alu_op;
                RegDst  = is_rtype;
                state_d = S_WB_A;
            end
            S_WB_A: begin
                ExtSel  = ext_sel;
                ALUSrcB = ~is_rtype;
                ALUOp   = alu_op;
                RegDst  = is_rtype;
                RegWre  = 1'b1;
                PCWre   = 1'b1;
                state_d = S_IF;
            end
            S_EXE_L: begin
                ExtSel  = ext_sel;
                ALUSrcB = 1'b1;
                ALUOp   = ALU_ADD;
                state_d = S_MEM;
            end
            S_MEM: begin
                ExtSel  = ext_sel;
                ALUSrcB = 1'b1;
                ALUOp   = ALU_ADD;
                if (is_sw) begin
                    mWR     = 1'b1;
                    PCWre   = 1'b1;
                    state_d = S_IF;
                end else begin
                    mRD     = 1'b1;
                    state_d = S_WB_L;
                end
            end
            S_WB_L: begin
                ExtSel    = ext_sel;
                ALUSrcB   = 1'b1;
                ALUOp     = ALU_ADD;
                RegWre    = 1'b1;
                DBDataSrc = 1'b1;
                mRD       = 1'b1;
                PCWre     = 1'b1;
                state_d   = S_IF;
            end
            S_EXE_B: begin
                ExtSel  = ext_sel;
                ALUOp   = ALU_SUB;
                PCWre   = 1'b1;
                PCSrc   = br_taken ? PC_BR : PC_SEQ;
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    assign state = state_q;

endmodule
